// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: latches decoded fields, forwards from
// EX/MEM and MEM/WB, builds immediate/shift operands and detects load-use hazards.
module id_ex_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [3:0]  id_ALUOperation,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic        id_ALUSrc,
  input  logic        id_ExtSign,
  input  logic        id_Shift,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        flush,
  input  logic        exmem_RegWrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic        stall,
  output logic        ex_valid,
  output logic [3:0]  ALUOperation,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite
);

  // Handshake: id_valid qualifies the ID fields; while stall=1 this stage does
  // not accept ID and the upstream stage must re-present the same instruction
  // next cycle; ex_valid qualifies every EX-side output.

  localparam logic [3:0] OP_AND = 4'b0000;

  logic        valid_q;
  logic [3:0]  op_q;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic [4:0]  rd_q;
  logic [31:0] rs_data_q;
  logic [31:0] rt_data_q;
  logic [31:0] imm_ext_q;
  logic [4:0]  shamt_q;
  logic        alusrc_q;
  logic        shift_q;
  logic        regwrite_q;
  logic        memread_q;
  logic        memwrite_q;

  logic [31:0] id_imm_ext;
  logic        rs_conflict;
  logic        rt_conflict;
  logic        load_use;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  assign id_imm_ext = id_ExtSign ? {{16{id_imm[15]}}, id_imm} : {16'b0, id_imm};

  // A load in EX cannot feed a dependent instruction in ID until one cycle later.
  always_comb begin
    rs_conflict = id_uses_rs && (id_rs == rd_q);
    rt_conflict = id_uses_rt && (id_rt == rd_q);
    load_use    = valid_q && memread_q && (rd_q != 5'd0) && id_valid &&
                  (rs_conflict || rt_conflict);
    stall       = !reset && load_use;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q    <= 1'b0;
      op_q       <= OP_AND;
      rs_q       <= 5'd0;
      rt_q       <= 5'd0;
      rd_q       <= 5'd0;
      rs_data_q  <= 32'd0;
      rt_data_q  <= 32'd0;
      imm_ext_q  <= 32'd0;
      shamt_q    <= 5'd0;
      alusrc_q   <= 1'b0;
      shift_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else if (flush || stall) begin
      // Bubble: data fields are left as they are since nothing consumes them.
      valid_q    <= 1'b0;
      op_q       <= OP_AND;
      alusrc_q   <= 1'b0;
      shift_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      valid_q    <= id_valid;
      op_q       <= id_ALUOperation;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      rd_q       <= id_rd;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_ext_q  <= id_imm_ext;
      shamt_q    <= id_shamt;
      alusrc_q   <= id_ALUSrc;
      shift_q    <= id_Shift;
      regwrite_q <= id_RegWrite;
      memread_q  <= id_MemRead;
      memwrite_q <= id_MemWrite;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 never forwards.
  always_comb begin
    fwd_rs = rs_data_q;
    if (rs_q != 5'd0) begin
      if (exmem_RegWrite && (exmem_rd == rs_q)) begin
        fwd_rs = exmem_result;
      end else if (memwb_RegWrite && (memwb_rd == rs_q)) begin
        fwd_rs = memwb_result;
      end
    end
  end

  always_comb begin
    fwd_rt = rt_data_q;
    if (rt_q != 5'd0) begin
      if (exmem_RegWrite && (exmem_rd == rt_q)) begin
        fwd_rt = exmem_result;
      end else if (memwb_RegWrite && (memwb_rd == rt_q)) begin
        fwd_rt = memwb_result;
      end
    end
  end

  // Shifts operate on rt by shamt; everything else is rs op (imm | rt).
  always_comb begin
    if (shift_q) begin
      A = fwd_rt;
      B = {27'b0, shamt_q};
    end else begin
      A = fwd_rs;
      B = alusrc_q ? imm_ext_q : fwd_rt;
    end
  end

  assign ex_store_data = fwd_rt;
  assign ex_valid      = valid_q;
  assign ALUOperation  = op_q;
  assign ex_rd         = rd_q;
  assign ex_RegWrite   = valid_q && regwrite_q;
  assign ex_MemRead    = valid_q && memread_q;
  assign ex_MemWrite   = valid_q && memwrite_q;

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It latches decoded instruction fields and register-file read data at the ID/EX boundary, then drives the ALU's `ALUOperation`, `A` and `B` inputs. It applies EX/MEM and MEM/WB forwarding, builds the immediate and shift-amount operands, and detects load-use hazards. It stalls the front end and inserts a bubble when a hazard occurs.

## Interface
- No parameters; the datapath is fixed at 32 bits, with 5-bit register addresses and a 4-bit ALU opcode.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  ID holds a real instruction.
- `id_ALUOperation`  in  4  ALU opcode: ADD 0011, SUB 0111, AND 0000, OR 0001, NOR 0101, LUI 0010, SLL 0100, SRL 0110.
- `id_rs`, `id_rt`, `id_rd`  in  5 each  source registers and destination register (destination already selected).
- `id_uses_rs`, `id_uses_rt`  in  1 each  the instruction actually reads that source.
- `id_rs_data`, `id_rt_data`  in  32 each  register-file read data.
- `id_imm`  in  16  immediate field.
- `id_shamt`  in  5  shift amount.
- `id_ALUSrc`  in  1  B comes from the extended immediate.
- `id_ExtSign`  in  1  1 = sign-extend the immediate, 0 = zero-extend.
- `id_Shift`  in  1  shift instruction.
- `id_RegWrite`, `id_MemRead`, `id_MemWrite`  in  1 each  control bits.
- `flush`  in  1  squash the incoming instruction (branch taken).
- `exmem_RegWrite`, `exmem_rd`, `exmem_result`  in  1/5/32  forwarding source from EX/MEM.
- `memwb_RegWrite`, `memwb_rd`, `memwb_result`  in  1/5/32  forwarding source from MEM/WB.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `ex_valid`  out  1  EX holds a real instruction.
- `ALUOperation`  out  4  to the ALU.
- `A`, `B`  out  32 each  ALU operands.
- `ex_store_data`  out  32  forwarded rt value for stores.
- `ex_rd`  out  5  destination register.
- `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`  out  1 each  control bits, gated by `ex_valid`.

## Operation
- **Registered state:** valid, opcode, rs/rt/rd, rs_data/rt_data, extended immediate, shamt, and all control bits.
- **Update priority each edge:** reset > flush > stall > load.
  - reset: every register clears to 0.
  - flush or stall: load a bubble. Valid and all control bits go to 0, opcode goes to AND (0000), data fields are don't-care.
  - otherwise: load the ID inputs.
- **Immediate extension at load:** `{{16{imm[15]}},imm}` when `ExtSign`=1, else `{16'b0,imm}`.
- **Forwarded values** `fwd_rs` and `fwd_rt` (combinational from registered state):
  - take `exmem_result` if `exmem_RegWrite` and `exmem_rd` == reg and reg != 0;
  - else `memwb_result` if `memwb_RegWrite` and `memwb_rd` == reg and reg != 0;
  - else the latched read data.
  - EX/MEM has priority over MEM/WB. Register 0 always reads the latched value, which the register file guarantees is 0.
- **Operand select:**
  - Shift=1: A = `fwd_rt`, B = `{27'b0,shamt}`.
  - Shift=0: A = `fwd_rs`; B = extended immediate if `ALUSrc`=1, else `fwd_rt`.
  - LUI relies on `ALUSrc`=1 with zero extension.
- **Store data:** `ex_store_data` = `fwd_rt` always.
- **Hazard detection:** `stall` = `ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd))`.
  - `stall` is combinational and forced to 0 while `reset` is high.
  - On a stall the upstream stage holds ID, so the instruction is re-presented and the hazard resolves after exactly one bubble.
- **Flush and stall together:** flush wins. A bubble is inserted and `stall` is still driven (harmless, since ID is being squashed upstream).

## Timing
- **Reset:** all outputs are 0 on the first edge with `reset`=1. This includes `ex_valid`, `ALUOperation`, `A`, `B`, `ex_store_data`, `ex_rd`, all control bits and `stall`. With zero forwarding inputs, A=B=0.
- **Latency:** an ID instruction appears on the EX outputs one edge after it is accepted.
- **Combinational paths:** forwarding and operand muxing are combinational from the registers and forwarding inputs within the same cycle, so a result in EX/MEM is usable by the dependent instruction in the immediately following cycle.
- **Load-use penalty:** exactly one cycle.
- **Reset mid-stall:** the stall is dropped on that edge and the pipeline is empty afterwards.

## Test plan
- **Reset:** assert reset with nonzero inputs → next edge all outputs 0. Deassert, then load ADD rs=1 (5), rt=2 (7) → next cycle ALUOperation=0011, A=5, B=7, ex_valid=1.
- **Forward priority:** EX holds rs=3, latched data 1; exmem rd=3 result 0xAA; memwb rd=3 result 0xBB → A=0xAA. Drop exmem_RegWrite → A=0xBB. Set rs=0 with both sources matching rd=0 → A=latched value 0.
- **Immediates and shifts:**
  - imm=0x8000, ExtSign=1, ALUSrc=1 → B=0xFFFF8000.
  - Same with ExtSign=0 → B=0x00008000.
  - SLL rt=0x1, shamt=4 → A=1, B=4.
- **Load-use:** lw into r8 in EX, ID has add using rs=8 → stall=1 for one cycle; next cycle ex_valid=0 with controls 0; following cycle add appears with stall=0.
- **No spurious stall:** lw r8 in EX, ID has id_uses_rt=0 with rt=8 → stall=0. lw into r0 → stall=0.
- **Flush vs stall:** flush=1 in the same cycle as a load-use hazard → bubble loaded and ex_valid=0. Flush with no hazard → bubble, and ID's instruction is not loaded.
